// File: rtl/ISO14443A_pkg.sv
// Shared ISO/IEC 14443-A timing constants and the FDT scheduler state type.
package ISO14443A_pkg;

  localparam int FDT_N9_LAST1 = 1236;
  localparam int FDT_N9_LAST0 = 1172;
  localparam int BIT_TICKS    = 128;
  localparam int CNT_W        = 12;

  typedef enum logic [1:0] {IDLE, RX, ARMED, TX} fdt_state_t;

  // First possible tx_go tick, measured from the last pause end.
  function automatic logic [CNT_W-1:0] fire_tick(input logic last_bit, input int fdt1,
                                                 input int fdt0, input int latency);
    return last_bit ? CNT_W'(fdt1 - latency) : CNT_W'(fdt0 - latency);
  endfunction

endpackage

// File: rtl/fdt_slot_timer.sv
// Pause-end timestamp counter plus the 128-tick response grid that follows the FDT.
module fdt_slot_timer
  import ISO14443A_pkg::*;
#(
  parameter int MAX_SLOTS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pause_n_synchronised,
  input  logic             in_rx,
  input  logic             armed,
  input  logic             arm_load,
  input  logic [CNT_W-1:0] t_fire,
  output logic             at_grid,
  output logic             slots_exhausted
);

  localparam int PH_W   = $clog2(BIT_TICKS);
  localparam int SLOT_W = $clog2(MAX_SLOTS + 1);

  logic              pause_q;
  logic              pause_rise;
  logic [CNT_W-1:0]  counter;
  logic [PH_W-1:0]   phase;
  logic [SLOT_W-1:0] slot;

  assign pause_rise = pause_n_synchronised & ~pause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b1;
      counter <= '0;
    end else begin
      pause_q <= pause_n_synchronised;
      if (in_rx && pause_rise)
        counter <= CNT_W'(1);
      else if (counter != '1)
        counter <= counter + 1'b1;
    end
  end

  // Phase only runs once the FDT has been reached; each wrap opens the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      slot  <= '0;
    end else if (arm_load) begin
      phase <= '0;
      slot  <= '0;
    end else if (armed && counter >= t_fire) begin
      phase <= phase + 1'b1;
      if (phase == PH_W'(BIT_TICKS - 1))
        slot <= slot + 1'b1;
    end
  end

  assign at_grid = armed && ((counter == t_fire) || ((counter > t_fire) && (phase == '0)));
  assign slots_exhausted = at_grid && (slot == SLOT_W'(MAX_SLOTS));

endmodule

// File: rtl/fdt_scheduler.sv
// PICC turnaround sequencer: times the FDT from the last PCD pause and launches the response.
//   state | meaning
//   IDLE  | waiting for a PCD frame
//   RX    | frame being received, timestamping each pause end
//   ARMED | frame ended, waiting for the FDT / next grid slot with tx_req
//   TX    | PICC transmitting, rx path gated off
module fdt_scheduler
  import ISO14443A_pkg::*;
#(
  parameter int FDT_LAST1  = FDT_N9_LAST1,
  parameter int FDT_LAST0  = FDT_N9_LAST0,
  parameter int TX_LATENCY = 2,
  parameter int MAX_SLOTS  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_n_synchronised,
  input  logic rx_soc,
  input  logic rx_eoc,
  input  logic rx_error,
  input  logic rx_data_valid,
  input  logic rx_data,
  input  logic tx_req,
  input  logic tx_done,
  output logic tx_go,
  output logic tx_missed,
  output logic rx_enable,
  output logic busy
);

  fdt_state_t       state, state_d;
  logic             last_bit, last_bit_d;
  logic [CNT_W-1:0] t_fire, t_fire_d;
  logic             tx_go_d, tx_missed_d;
  logic             arm_load;
  logic             at_grid, slots_exhausted;

  fdt_slot_timer #(.MAX_SLOTS(MAX_SLOTS)) u_slot_timer (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pause_n_synchronised (pause_n_synchronised),
    .in_rx                (state == RX),
    .armed                (state == ARMED),
    .arm_load             (arm_load),
    .t_fire               (t_fire),
    .at_grid              (at_grid),
    .slots_exhausted      (slots_exhausted)
  );

  always_comb begin
    state_d     = state;
    last_bit_d  = last_bit;
    t_fire_d    = t_fire;
    tx_go_d     = 1'b0;
    tx_missed_d = 1'b0;
    arm_load    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_soc) begin
          state_d    = RX;
          last_bit_d = 1'b0;
        end
      end
      RX: begin
        if (rx_error) begin
          state_d = IDLE;
        end else if (rx_soc) begin
          last_bit_d = 1'b0;
        end else if (rx_eoc) begin
          state_d  = ARMED;
          t_fire_d = fire_tick(last_bit, FDT_LAST1, FDT_LAST0, TX_LATENCY);
          arm_load = 1'b1;
        end else if (rx_data_valid) begin
          last_bit_d = rx_data;
        end
      end
      ARMED: begin
        // A PCD retransmission always takes precedence over launching a response.
        if (rx_soc) begin
          state_d    = RX;
          last_bit_d = 1'b0;
        end else if (at_grid && tx_req) begin
          state_d = TX;
          tx_go_d = 1'b1;
        end else if (slots_exhausted) begin
          state_d     = IDLE;
          tx_missed_d = 1'b1;
        end
      end
      TX: begin
        if (tx_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_bit  <= 1'b0;
      t_fire    <= '0;
      tx_go     <= 1'b0;
      tx_missed <= 1'b0;
      rx_enable <= 1'b1;
    end else begin
      state     <= state_d;
      last_bit  <= last_bit_d;
      t_fire    <= t_fire_d;
      tx_go     <= tx_go_d;
      tx_missed <= tx_missed_d;
      rx_enable <= (state_d != TX);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fdt_scheduler.sv
// Bench for fdt_scheduler: directed FDT table, randomized tx_req timing and corner sequences.
module tb_fdt_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_n = 1'b1;
  logic rx_soc = 1'b0, rx_eoc = 1'b0, rx_error = 1'b0;
  logic rx_data_valid = 1'b0, rx_data = 1'b0;
  logic tx_req = 1'b0, tx_done = 1'b0;
  logic tx_go, tx_missed, rx_enable, busy;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fdt_scheduler dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pause_n_synchronised (pause_n),
    .rx_soc               (rx_soc),
    .rx_eoc               (rx_eoc),
    .rx_error             (rx_error),
    .rx_data_valid        (rx_data_valid),
    .rx_data              (rx_data),
    .tx_req               (tx_req),
    .tx_done              (tx_done),
    .tx_go                (tx_go),
    .tx_missed            (tx_missed),
    .rx_enable            (rx_enable),
    .busy                 (busy)
  );

  typedef struct {
    bit lastb;
    int req_rise;   // tick at which tx_req goes high, -1 = never
    int exp_go;
    int exp_miss;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // tx_req level at a tick: an optional early pulse [a,b) plus a level from c onward.
  function automatic bit req_high(input int k, input int a, input int b, input int c);
    return (k >= a && k < b) || (c >= 0 && k >= c);
  endfunction

  // Reference: first grid point FDT-2 + 128*m (m = 0..16) where tx_req is high, else a miss.
  task automatic model(input bit lastb, input int a, input int b, input int c,
                       output int go, output int miss);
    int t;
    t = (lastb ? 1236 : 1172) - 2;
    go = -1;
    miss = -1;
    for (int m = 0; m <= 16; m++) begin
      if (go < 0 && req_high(t + 128 * m, a, b, c)) go = t + 128 * m;
    end
    if (go < 0) miss = t + 16 * 128;
  endtask

  task automatic clear_inputs();
    rx_soc = 0; rx_eoc = 0; rx_error = 0; rx_data_valid = 0; rx_data = 0;
    tx_req = 0; tx_done = 0; pause_n = 1;
  endtask

  // Drives one PCD frame; tick 0 is the clock edge that sees the last pause end.
  task automatic run_frame(input bit start_soc, input bit lastb, input int a, input int b,
                           input int c, input int abort_k,
                           output int go_k, output int go_cnt, output int miss_k,
                           output int miss_cnt, output int rxen_bad);
    int stop_k;
    go_k = -1; go_cnt = 0; miss_k = -1; miss_cnt = 0; rxen_bad = 0; stop_k = 3600;
    @(negedge clk);
    if (start_soc) begin
      rx_soc = 1; @(negedge clk); rx_soc = 0;
    end
    for (int i = 0; i < 3; i++) begin
      pause_n = 0; repeat (3) @(negedge clk);
      pause_n = 1; repeat (12) @(negedge clk);
      rx_data_valid = 1; rx_data = 1'($urandom_range(0, 1)); @(negedge clk);
      rx_data_valid = 0; repeat (20) @(negedge clk);
    end
    pause_n = 0; repeat (4) @(negedge clk);
    pause_n = 1;
    for (int k = 0; k <= stop_k; k++) begin
      @(negedge clk);
      if (tx_go) begin
        go_cnt++;
        if (go_k < 0) begin go_k = k; if (k + 4 < stop_k) stop_k = k + 4; end
      end
      if (tx_missed) begin
        miss_cnt++;
        if (miss_k < 0) begin miss_k = k; if (k + 4 < stop_k) stop_k = k + 4; end
      end
      if (go_k >= 0 && k > go_k && rx_enable) rxen_bad++;
      if (abort_k >= 0 && k == abort_k) break;
      rx_data_valid = (k + 1 == 20);
      rx_data       = lastb;
      rx_eoc        = (k + 1 == 150);
      pause_n       = !((k + 1) >= 600 && (k + 1) < 603);
      rx_soc        = (k + 1 == abort_k);
      tx_req        = (go_k < 0) && req_high(k + 1, a, b, c);
      tx_done       = (k + 1 == 700);
    end
    clear_inputs();
  endtask

  task automatic frame_checks(input string tag, input int exp_go, input int exp_miss,
                              input int go_k, input int go_cnt, input int miss_k,
                              input int miss_cnt, input int rxen_bad);
    check({tag, " go_tick"}, go_k, exp_go);
    check({tag, " go_count"}, go_cnt, (exp_go >= 0) ? 1 : 0);
    check({tag, " miss_tick"}, miss_k, exp_miss);
    check({tag, " miss_count"}, miss_cnt, (exp_miss >= 0) ? 1 : 0);
    if (go_k >= 0) begin
      check({tag, " rx_enable_in_tx"}, rxen_bad, 0);
      check({tag, " busy_in_tx"}, int'(busy), 1);
      tx_done = 1; @(negedge clk); tx_done = 0;
      check({tag, " rx_enable_after_done"}, int'(rx_enable), 1);
      check({tag, " busy_after_done"}, int'(busy), 0);
    end else begin
      check({tag, " busy_after_miss"}, int'(busy), 0);
    end
  endtask

  initial begin
    int go_k, go_cnt, miss_k, miss_cnt, rxen_bad, eg, em, cnt, a, b, c;
    vecs[0] = '{1, 0,    1234, -1};
    vecs[1] = '{0, 0,    1170, -1};
    vecs[2] = '{1, 1300, 1362, -1};
    vecs[3] = '{1, -1,   -1,   3282};
    vecs[4] = '{0, 1171, 1298, -1};
    vecs[5] = '{1, 3282, 3282, -1};
    vecs[6] = '{1, 3283, -1,   3282};
    vecs[7] = '{0, 1170, 1170, -1};

    clear_inputs();
    repeat (3) @(negedge clk);
    check("reset tx_go", int'(tx_go), 0);
    check("reset tx_missed", int'(tx_missed), 0);
    check("reset rx_enable", int'(rx_enable), 1);
    check("reset busy", int'(busy), 0);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      run_frame(1, vecs[i].lastb, 0, 0, vecs[i].req_rise, -1,
                go_k, go_cnt, miss_k, miss_cnt, rxen_bad);
      frame_checks($sformatf("vec%0d", i), vecs[i].exp_go, vecs[i].exp_miss,
                   go_k, go_cnt, miss_k, miss_cnt, rxen_bad);
    end

    // Random tx_req timing, including a withdrawn pulse before the FDT.
    for (int i = 0; i < 8; i++) begin
      bit lb;
      lb = 1'($urandom_range(0, 1));
      a = $urandom_range(200, 1000);
      b = a + $urandom_range(1, 100);
      c = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(160, 2600);
      model(lb, a, b, c, eg, em);
      run_frame(1, lb, a, b, c, -1, go_k, go_cnt, miss_k, miss_cnt, rxen_bad);
      frame_checks($sformatf("rnd%0d", i), eg, em, go_k, go_cnt, miss_k, miss_cnt, rxen_bad);
    end

    // IDLE ignores tx_req; rx_error aborts a frame with no response.
    cnt = 0;
    tx_req = 1;
    repeat (200) begin @(negedge clk); if (tx_go) cnt++; end
    rx_soc = 1; @(negedge clk); rx_soc = 0;
    repeat (30) @(negedge clk);
    check("rx_busy_before_error", int'(busy), 1);
    rx_error = 1; @(negedge clk); rx_error = 0;
    check("busy_after_error", int'(busy), 0);
    repeat (1500) begin @(negedge clk); if (tx_go || tx_missed) cnt++; end
    check("no_tx_after_idle_or_error", cnt, 0);
    clear_inputs();

    // rx_soc in ARMED at tick 1000 discards the slot; the next frame re-times.
    run_frame(1, 1, 0, 0, 0, 1000, go_k, go_cnt, miss_k, miss_cnt, rxen_bad);
    check("abort go_count", go_cnt, 0);
    check("abort busy", int'(busy), 1);
    run_frame(0, 1, 0, 0, 0, -1, go_k, go_cnt, miss_k, miss_cnt, rxen_bad);
    frame_checks("retime", 1234, -1, go_k, go_cnt, miss_k, miss_cnt, rxen_bad);

    // Reset asserted while transmitting.
    run_frame(1, 0, 0, 0, 0, -1, go_k, go_cnt, miss_k, miss_cnt, rxen_bad);
    check("pre_reset go_tick", go_k, 1170);
    check("pre_reset rx_enable", int'(rx_enable), 0);
    #2 rst_n = 0;
    #1;
    check("rst_tx tx_go", int'(tx_go), 0);
    check("rst_tx tx_missed", int'(tx_missed), 0);
    check("rst_tx rx_enable", int'(rx_enable), 1);
    check("rst_tx busy", int'(busy), 0);
    @(negedge clk); rst_n = 1;
    run_frame(1, 1, 0, 0, 1250, -1, go_k, go_cnt, miss_k, miss_cnt, rxen_bad);
    frame_checks("post_reset", 1362, -1, go_k, go_cnt, miss_k, miss_cnt, rxen_bad);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fdt_scheduler.md
Name: fdt_scheduler

Overview:
- Sequences the PICC turnaround after the PCD→PICC rx path (sequence decoder, then rx interface) finishes a frame.
- Timestamps the end of the last PCD pause and enforces the ISO/IEC 14443-3 frame delay time (FDT): the response starts at the FDT for n=9, or on a later 128-tick grid slot.
- Gates the rx path off while the PICC transmits.
- Sits between the rx decoder, the frame/application layer (tx_req) and the tx encoder (tx_go/tx_done).

Parameters:
- FDT_LAST1, 1236, FDT in clk ticks from last pause end when the last data bit was 1.
- FDT_LAST0, 1172, FDT in clk ticks when the last data bit was 0.
- TX_LATENCY, 2, ticks from tx_go to the first modulated edge in the tx encoder; subtracted from the FDT.
- MAX_SLOTS, 16, number of extra 128-tick slots allowed after the FDT before giving up. Constraint: FDT_LAST1 + 128*MAX_SLOTS < 4096.

Ports:
- clk  in  1  13.56 MHz recovered carrier clock
- rst_n  in  1  reset
- pause_n_synchronised  in  1  synchronised pause_n; 0 during pause
- rx_soc  in  1  1-tick pulse, start of frame
- rx_eoc  in  1  1-tick pulse, end of frame
- rx_error  in  1  1-tick pulse, timing error
- rx_data_valid  in  1  1-tick strobe for rx_data
- rx_data  in  1  decoded bit
- tx_req  in  1  level; response ready to send; held until tx_go
- tx_done  in  1  1-tick pulse from tx encoder, transmission finished
- tx_go  out  1  1-tick pulse, start transmission now
- tx_missed  out  1  1-tick pulse, no tx_req within MAX_SLOTS
- rx_enable  out  1  1 = rx path may accept frames
- busy  out  1  1 when state is not IDLE

Behaviour:
- Reset is asynchronous (rst_n, active-low) on clk.
- Reset values: state IDLE, counter 0, last_bit 0, slot 0, phase 0, tx_go 0, tx_missed 0, rx_enable 1, busy 0.
- Pause end detection: rising edge of pause_n_synchronised, using a registered copy reset to 1.
- counter: 12-bit timer.
  - In RX, a pause end loads counter with 1; otherwise counter increments and saturates at 4095.
  - In ARMED, counter increments and pause edges are ignored.
- last_bit: captures rx_data on each rx_data_valid in RX.
- T_fire = (last_bit ? FDT_LAST1 : FDT_LAST0) − TX_LATENCY, evaluated when rx_eoc arrives.
- FSM states: IDLE, RX, ARMED, TX.
  - IDLE → RX on rx_soc. All other inputs are ignored, including tx_req.
  - RX → ARMED on rx_eoc. Latch T_fire; clear slot and phase.
  - RX → IDLE on rx_error. No tx.
  - RX: rx_soc restarts RX and clears last_bit.
  - ARMED: counter reaching T_fire starts phase, a 7-bit counter that wraps at 128. Each wrap increments slot.
  - ARMED: tx_go is high for exactly the one cycle where (counter == T_fire or (counter > T_fire and phase == 0)) and tx_req == 1. Next state is TX.
  - ARMED: if slot == MAX_SLOTS at a slot boundary and tx_req == 0, pulse tx_missed and go to IDLE.
  - ARMED: rx_soc (PCD retransmitted) → RX, discarding the armed slot. rx_soc wins over a coincident fire.
  - TX: rx_enable = 0; tx_done → IDLE with rx_enable = 1 in the next cycle. rx_soc and rx_eoc are ignored.
- A tx_req that asserts mid-slot waits for the next grid point. It never fires before T_fire and never off-grid.
- A tx_req asserted and deasserted before T_fire is treated as withdrawn; only the level at the grid point counts.
- tx_done outside TX is ignored.
- tx_go and tx_missed never assert in the same cycle.
- Reset mid-operation returns everything to reset values immediately, including mid-TX.
- busy = (state != IDLE); combinational from the state register.

Decomposition:
- Shared package ISO14443A_pkg:
  - FDT_N9_LAST1 = 1236 and FDT_N9_LAST0 = 1172
  - BIT_TICKS = 128
  - typedef enum fdt_state_t {IDLE, RX, ARMED, TX}
- Sub-module fdt_slot_timer: owns the pause-edge detector, counter, phase and slot. Its outputs are at_grid (counter == T_fire or phase wrap past T_fire) and slots_exhausted. The top level holds the FSM and output registers.

Test Plan:
- Frame ending in data bit 1, last pause end at t0, tx_req already high → tx_go exactly 1234 ticks after t0; rx_enable low until tx_done.
- Same frame but last bit 0 → tx_go at 1170 ticks; no pulse at 1234.
- Last bit 1, tx_req rises at 1300 ticks → tx_go at 1362 (1234+128), not at 1300.
- tx_req never asserted, MAX_SLOTS=16 → tx_missed once at 1234+16·128 = 3282 ticks; state IDLE; tx_go never asserts.
- rx_error mid-frame, then tx_req high → no tx_go; busy falls the cycle after the error. rx_soc in ARMED at tick 1000 → returns to RX; the next frame re-times the FDT from its own last pause.
- rst_n low during TX → tx_go/tx_missed 0 and rx_enable 1 immediately; the following frame schedules normally.
